apb_uart_rx: RTL and testbench
==============================

Name: apb_uart_rx

Overview:
APB slave UART receiver. It is the receive-side counterpart of the existing UART transmitter peripheral and hangs off one PSELx slot of the peripheral interconnect. It oversamples rx_wire, deserialises 8N1 frames and buffers the bytes in a FIFO. Cores pop bytes and read status through zero-wait APB accesses.

Parameters:
BUS_WIDTH, 16, APB address width
DATA_WIDTH, 16, APB data width
ADDR_EXP, 4, log2 of FIFO depth (16 bytes)
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
S_PADDR  in  BUS_WIDTH  APB address; only S_PADDR[0] decoded
S_PWRITE  in  1  APB write strobe
S_PSELx  in  1  APB slave select
S_PENABLE  in  1  APB access phase
S_PWDATA  in  DATA_WIDTH  APB write data
S_PRDATA  out  DATA_WIDTH  APB read data
S_PREADY  out  1  APB ready
rx_wire  in  1  asynchronous UART serial input, idle high

Behaviour:
- Reset: S_PREADY=0, S_PRDATA=0, FIFO empty, sticky flags clear, FSM=IDLE, both synchroniser flops=1.
- APB: S_PREADY = S_PSELx & S_PENABLE (combinational, zero wait). S_PRDATA is combinational and valid while S_PREADY=1. S_PRDATA=0 otherwise.
- Offset 0 (DATA) read: S_PRDATA = {7'b0, valid, byte}. valid=1 iff FIFO is non-empty. The FIFO pops on the clock edge that ends the access cycle.
- DATA read when the FIFO is empty: returns 0x0000, no pointer change. Writes to DATA are ignored.
- Offset 1 (STATUS) read: bit0 empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bits[15:8] = FIFO count. Reading STATUS has no side effect.
- STATUS write: writing 1 to bit2 or bit3 clears that flag. Other bits are ignored.
- Input sampling: rx_wire passes through a 2-flop synchroniser, giving rx_s. A falling edge is detected from rx_s and its registered copy.
- FSM states:
  - IDLE: on a rx_s falling edge, load bit counter=0 and baud counter=CLKS_PER_BIT/2-1, go to START.
  - START: when the baud counter reaches 0, sample rx_s. If 0, reload the baud counter with CLKS_PER_BIT-1 and go to DATA. If 1, treat it as a glitch and return to IDLE with nothing recorded.
  - DATA: at each baud counter expiry, shift rx_s into bit[bitcnt] (LSB first). After bit 7, go to STOP.
  - STOP: at expiry, sample rx_s.
    - If 1 and FIFO not full: push the byte.
    - If 1 and FIFO full: drop the byte and set overrun.
    - If 0: drop the byte and set frame_err.
    - In all three cases return to IDLE.
- A line held low (break) does not retrigger, because IDLE requires a new falling edge.
- Latency: the byte is visible in STATUS/DATA on the cycle after the stop-bit sample edge.
- Simultaneous push and APB pop in one cycle: both occur, count unchanged. If the FIFO was empty, the pop returns empty (0x0000) and the push lands.
- Simultaneous push setting overrun and a STATUS write clearing it: set wins.
- FIFO pointers are ADDR_EXP+1 bits; wrap-around is natural modulo. full = count == 2^ADDR_EXP.
- Reset mid-frame aborts the frame, empties the FIFO and returns the FSM to IDLE on the next edge.

Decomposition:
- Register offsets (DATA=0, STATUS=1) and STATUS bit positions go in the shared SoC config header, next to the APB_PSELX_* slot defines.
- Add a new APB_PSELX_UART1 slot define there.
- One sub-module, uart_rx_fifo: a synchronous FIFO with push, pop, dout, empty, full and count, parameterised by width 8 and ADDR_EXP. It is reusable by the transmitter.
- The receive FSM and the APB decode stay in apb_uart_rx.

Test Plan (all with CLKS_PER_BIT=8):
- Single frame 0xA5, then DATA read -> PRDATA=0x01A5; subsequent STATUS read -> 0x0001 (empty, count 0).
- Frames 0x00, 0xFF, 0x3C back-to-back, then three DATA reads -> 0x0100, 0x01FF, 0x013C in order. A fourth read -> 0x0000.
- 17 frames with no reads -> STATUS = 0x1006 (count 16, full, overrun). 16 DATA reads return the first 16 bytes; the 17th is lost.
- Frame 0x55 with stop bit driven 0 -> STATUS bit3=1 and FIFO empty. Write 0x0008 to STATUS -> bit3 reads 0.
- Low pulse of 2 clks on an idle line -> no byte, no flags. Then a valid frame 0x81 -> DATA reads 0x0181.
- Reset asserted after data bit 3 of a frame, then a valid 0x42 frame -> FIFO holds only 0x42, flags clear.

Source files
------------

// File: rtl/apb_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_rx_pkg
// Brief    : Shared SoC config: APB slot selects, UART RX register map, FSM states
// Revision : 1.0 - initial release
// ============================================================================
package apb_uart_rx_pkg;

    // APB PSELx slot assignments on the peripheral interconnect
    localparam int c_apb_pselx_uart1 = 5;

    // Register offsets (decoded from PADDR[0])
    localparam logic c_off_data   = 1'b0;
    localparam logic c_off_status = 1'b1;

    // STATUS register bit positions
    localparam int c_st_empty     = 0;
    localparam int c_st_full      = 1;
    localparam int c_st_overrun   = 2;
    localparam int c_st_frame_err = 3;
    localparam int c_st_count_lsb = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous FIFO with occupancy count; shared by UART RX and TX
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import apb_uart_rx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_EXP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [WIDTH-1:0]    i_din,
    output logic [WIDTH-1:0]    o_dout,
    output logic                o_empty,
    output logic                o_full,
    output logic [ADDR_EXP:0]   o_count
);

    localparam logic [ADDR_EXP:0] c_depth = {1'b1, {ADDR_EXP{1'b0}}};

    logic [WIDTH-1:0]  r_mem [0:(1<<ADDR_EXP)-1];
    logic [ADDR_EXP:0] r_wptr;
    logic [ADDR_EXP:0] r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer MSB disambiguates full from empty; wrap is natural modulo
    assign o_count   = r_wptr - r_rptr;
    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == c_depth);
    assign o_dout    = r_mem[r_rptr[ADDR_EXP-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[ADDR_EXP-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_rx
// Brief    : APB slave UART receiver (8N1, oversampled) with byte FIFO
// Revision : 1.0 - initial release
// ============================================================================
module apb_uart_rx
    import apb_uart_rx_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_EXP     = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    input  logic                  rx_wire
);

    localparam int                c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_full = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_half = c_baud_w'(CLKS_PER_BIT / 2 - 1);

    logic                r_sync1;
    logic                r_rx_s;
    logic                r_rx_prev;
    rx_state_t           r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic                r_overrun;
    logic                r_frame_err;

    logic                w_fall;
    logic                w_baud_done;
    logic                w_stop_sample;
    logic                w_push;
    logic                w_overrun_set;
    logic                w_frame_set;
    logic                w_rd_access;
    logic                w_pop;
    logic                w_wr_status;
    logic [15:0]         w_rdata;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [ADDR_EXP:0]   w_fifo_count;
    logic [7:0]          w_fifo_dout;
    logic                w_unused_ok;

    assign S_PREADY      = S_PSELx & S_PENABLE;
    assign w_rd_access   = S_PREADY & ~S_PWRITE;
    assign w_pop         = w_rd_access & (S_PADDR[0] == c_off_data) & ~w_fifo_empty;
    assign w_wr_status   = S_PREADY & S_PWRITE & (S_PADDR[0] == c_off_status);
    assign w_unused_ok   = ^{S_PADDR, S_PWDATA};

    assign w_fall        = r_rx_prev & ~r_rx_s;
    assign w_baud_done   = (r_baud == '0);
    // Stop-bit outcome is decoded combinationally so the byte lands on the sample edge
    assign w_stop_sample = (r_state == ST_STOP) & w_baud_done;
    assign w_push        = w_stop_sample & r_rx_s & ~w_fifo_full;
    assign w_overrun_set = w_stop_sample & r_rx_s & w_fifo_full;
    assign w_frame_set   = w_stop_sample & ~r_rx_s;

    always_comb begin
        w_rdata = '0;
        if (w_rd_access) begin
            if (S_PADDR[0] == c_off_data) begin
                if (!w_fifo_empty) w_rdata = {7'b0, 1'b1, w_fifo_dout};
            end else begin
                w_rdata[c_st_empty]           = w_fifo_empty;
                w_rdata[c_st_full]            = w_fifo_full;
                w_rdata[c_st_overrun]         = r_overrun;
                w_rdata[c_st_frame_err]       = r_frame_err;
                w_rdata[c_st_count_lsb +: 8]  = 8'(w_fifo_count);
            end
        end
    end
    assign S_PRDATA = DATA_WIDTH'(w_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_wire;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // Set beats a same-cycle software clear so no error event is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr_status && S_PWDATA[c_st_overrun])   r_overrun   <= 1'b0;
            if (w_wr_status && S_PWDATA[c_st_frame_err]) r_frame_err <= 1'b0;
            if (w_overrun_set) r_overrun   <= 1'b1;
            if (w_frame_set)   r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_bitcnt <= '0;
                        r_baud   <= c_baud_half;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_baud_done) begin
                        r_baud <= r_baud - c_baud_w'(1);
                    end else if (!r_rx_s) begin
                        r_baud  <= c_baud_full;
                        r_state <= ST_DATA;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_baud_done) begin
                        r_baud <= r_baud - c_baud_w'(1);
                    end else begin
                        r_shift[r_bitcnt] <= r_rx_s;
                        r_baud            <= c_baud_full;
                        if (r_bitcnt == 3'd7) r_state  <= ST_STOP;
                        else                  r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (!w_baud_done) r_baud  <= r_baud - c_baud_w'(1);
                    else              r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH    (8),
        .ADDR_EXP (ADDR_EXP)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_uart_rx
// Brief    : Directed self-checking bench for apb_uart_rx with byte scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_uart_rx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        rx;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        m_ovr;
    logic        m_fe;
    logic [15:0] rd;

    apb_uart_rx #(
        .BUS_WIDTH    (16),
        .DATA_WIDTH   (16),
        .ADDR_EXP     (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
        .rx_wire   (rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [7:0] cnt;
        cnt = 8'(exp_q.size());
        return {cnt, 4'b0, m_fe, m_ovr, (exp_q.size() == 16), (exp_q.size() == 0)};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(2);
        if (!stop)                 m_fe = 1'b1;
        else if (exp_q.size() < 16) exp_q.push_back(b);
        else                       m_ovr = 1'b1;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [15:0] d);
        paddr   = a;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        tick(1);
        penable = 1'b1;
        #1;
        d = prdata;
        tick(1);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [15:0] d);
        paddr   = a;
        pwrite  = 1'b1;
        pwdata  = d;
        psel    = 1'b1;
        penable = 1'b0;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        if (a[0]) begin
            if (d[2]) m_ovr = 1'b0;
            if (d[3]) m_fe  = 1'b0;
        end
    endtask

    task automatic check_data(input string tag);
        logic [15:0] exp;
        exp = 16'h0000;
        if (exp_q.size() != 0) exp = {8'h01, exp_q.pop_front()};
        apb_read(16'h0000, rd);
        check(tag, rd, exp);
    endtask

    task automatic check_status(input string tag);
        logic [15:0] exp;
        exp = model_status();
        apb_read(16'h0001, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        m_ovr = 1'b0; m_fe = 1'b0;
        tick(3);
        check("reset_pready", {15'b0, pready}, 16'h0000);
        check("reset_prdata", prdata, 16'h0000);
        reset = 1'b0;
        tick(2);
        check_status("reset_status");

        // Single frame, then STATUS shows empty again
        send_frame(8'hA5, 1'b1);
        check_data("a5_data");
        check_status("a5_status");

        // Back-to-back frames read out in order, then an empty read
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        check_status("three_status");
        check_data("three_data0");
        check_data("three_data1");
        check_data("three_data2");
        check_data("three_empty");

        // Overflow: 17 frames without draining
        for (int i = 0; i < 17; i++) send_frame(8'(i * 13 + 7), 1'b1);
        check_status("full_status");
        for (int i = 0; i < 16; i++) check_data($sformatf("full_data%0d", i));
        check_data("full_lost");
        apb_write(16'h0001, 16'h0004);
        check_status("ovr_cleared");

        // Framing error and its clear
        send_frame(8'h55, 1'b0);
        check_status("fe_status");
        apb_write(16'h0001, 16'h0008);
        check_status("fe_cleared");

        // Short glitch is rejected, next good frame is received
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3 * CPB);
        check_status("glitch_status");
        send_frame(8'h81, 1'b1);
        check_data("glitch_next_data");

        // Reset mid-frame after stored data and a raised flag
        send_frame(8'h11, 1'b1);
        send_frame(8'h33, 1'b0);
        check_status("pre_reset_status");
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (i[0] == 1'b0);
            tick(CPB);
        end
        reset = 1'b1;
        rx    = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        tick(2 * CPB);
        check_status("post_reset_status");
        send_frame(8'h42, 1'b1);
        check_status("post_reset_one");
        check_data("post_reset_data");
        check_status("post_reset_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
